// File: rtl/ts_pkt_arb_if.sv
// Stream/handshake bundle between the 4 TS channel buffers, the packet arbiter
// and the downstream PCR-correct delay path.
interface ts_pkt_arb_if;
  logic        arb_en;
  logic [3:0]  pkt_rdy;
  logic [31:0] ch_data;
  logic [3:0]  rd_en;
  logic        ts_sync;
  logic        ts_valid;
  logic [7:0]  ts_data;
  logic [1:0]  grant_id;
  logic        busy;
  logic        sync_err;

  modport master (
    input  arb_en, pkt_rdy, ch_data,
    output rd_en, ts_sync, ts_valid, ts_data, grant_id, busy, sync_err
  );

  modport slave (
    output arb_en, pkt_rdy, ch_data,
    input  rd_en, ts_sync, ts_valid, ts_data, grant_id, busy, sync_err
  );
endinterface

// File: rtl/ts_pkt_arb.sv
// Packet-level round-robin arbiter: grants one whole TS packet at a time from 4 buffers.
// Optional macro TS_ARB_CH0_PRIO_EN gives channel 0 strict priority; 1-3 rotate among themselves.
module ts_pkt_arb #(
  parameter int          PKT_LEN   = 188,
  parameter int          GAP_CYC   = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'h47
) (
  input  logic          clk,
  input  logic          rst_n,
  ts_pkt_arb_if.master  bus
);

  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_GAP} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [BW-1:0]   r_byte_cnt;
  logic [GW-1:0]   r_gap_cnt;
  logic [1:0]      r_last_grant;
  logic [1:0]      r_grant_id;
  logic [1:0]      w_pick;
  logic            w_pick_vld;
  logic [3:0]      w_req;
  logic            w_byte_last;
  logic            w_gap_last;
  logic [3:0]      w_rd;

  logic            r_p1_vld;
  logic            r_p1_first;
  logic [1:0]      r_p1_ch;
  logic            r_ts_valid;
  logic            r_ts_sync;
  logic [7:0]      r_ts_data;
  logic            r_sync_err;
  logic [7:0]      w_byte;

  // First requester after the pointer, searching last+1 .. last+4 (mod 4).
  always_comb begin
    w_pick     = '0;
    w_pick_vld = 1'b0;
    w_req      = bus.pkt_rdy;
`ifdef TS_ARB_CH0_PRIO_EN
    if (bus.pkt_rdy[0]) begin
      w_pick     = 2'd0;
      w_pick_vld = 1'b1;
    end
    w_req[0] = 1'b0;
`endif
    for (int unsigned k = 1; k <= 4; k++) begin
      if (!w_pick_vld && w_req[r_last_grant + 2'(k)]) begin
        w_pick     = r_last_grant + 2'(k);
        w_pick_vld = 1'b1;
      end
    end
  end

  assign w_byte_last = (r_byte_cnt == BW'(PKT_LEN - 1));
  assign w_gap_last  = (r_gap_cnt == GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.arb_en && w_pick_vld) w_next = S_READ;
      S_READ: if (w_byte_last) w_next = (GAP_CYC > 0) ? S_GAP : S_IDLE;
      S_GAP:  if (w_gap_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_byte_cnt   <= '0;
      r_gap_cnt    <= '0;
      r_last_grant <= 2'd3;
      r_grant_id   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_next == S_READ) begin
            r_grant_id <= w_pick;
            r_byte_cnt <= '0;
          end
        end
        S_READ: begin
          if (w_byte_last) begin
            r_byte_cnt <= '0;
            r_gap_cnt  <= '0;
`ifdef TS_ARB_CH0_PRIO_EN
            // Channel-0 grants leave the 1..3 rotation untouched.
            if (r_grant_id != 2'd0) r_last_grant <= r_grant_id;
`else
            r_last_grant <= r_grant_id;
`endif
          end else begin
            r_byte_cnt <= r_byte_cnt + BW'(1);
          end
        end
        S_GAP:   r_gap_cnt <= r_gap_cnt + GW'(1);
        default: ;
      endcase
    end
  end

  assign w_rd = (r_state == S_READ) ? (4'b0001 << r_grant_id) : '0;

  // Buffer returns the byte one cycle after rd_en; it is captured on the following edge.
  assign w_byte = bus.ch_data[{r_p1_ch, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1_vld   <= 1'b0;
      r_p1_first <= 1'b0;
      r_p1_ch    <= '0;
      r_ts_valid <= 1'b0;
      r_ts_sync  <= 1'b0;
      r_ts_data  <= '0;
      r_sync_err <= 1'b0;
    end else begin
      r_p1_vld   <= (r_state == S_READ);
      r_p1_first <= (r_state == S_READ) && (r_byte_cnt == '0);
      r_p1_ch    <= r_grant_id;
      r_ts_valid <= r_p1_vld;
      r_ts_sync  <= r_p1_first;
      r_sync_err <= r_p1_first && (w_byte != SYNC_BYTE);
      if (r_p1_vld) r_ts_data <= w_byte;
    end
  end

  assign bus.rd_en    = w_rd;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.grant_id = r_grant_id;
  assign bus.ts_valid = r_ts_valid;
  assign bus.ts_sync  = r_ts_sync;
  assign bus.ts_data  = r_ts_data;
  assign bus.sync_err = r_sync_err;

endmodule

// File: tb/tb_ts_pkt_arb.sv
// Self-checking bench for ts_pkt_arb: packet-schedule model plus directed scenarios.
// Build with +define+TS_ARB_CH0_PRIO_EN to exercise the channel-0 priority variant.
module tb_ts_pkt_arb;

  localparam int PKT = 188;
  localparam int GAP = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ts_pkt_arb_if ifc ();

  ts_pkt_arb #(.PKT_LEN(PKT), .GAP_CYC(GAP), .SYNC_BYTE(8'h47)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Channel content: byte 0 is the sync byte unless bad_first is set for that channel.
  logic bad_first [4];

  function automatic logic [7:0] pat(input int ch, input int pkt, input int idx);
    if (idx == 0) return bad_first[ch] ? 8'h00 : 8'h47;
    return 8'((idx * 3 + ch * 50 + pkt * 7) & 255);
  endfunction

  // Channel buffers: present the next byte the cycle after each read strobe.
  int d_cnt [4];
  int d_pkt [4];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifc.ch_data <= '0;
      for (int i = 0; i < 4; i++) begin
        d_cnt[i] <= 0;
        d_pkt[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (ifc.rd_en[i]) begin
          ifc.ch_data[8*i +: 8] <= pat(i, d_pkt[i], d_cnt[i]);
          if (d_cnt[i] == PKT - 1) begin
            d_cnt[i] <= 0;
            d_pkt[i] <= d_pkt[i] + 1;
          end else begin
            d_cnt[i] <= d_cnt[i] + 1;
          end
        end
      end
    end
  end

  // Model: m_off = cycles since grant (0 = free); 1..PKT read, PKT+1..PKT+GAP gap.
  int         m_off;
  logic [1:0] m_gid;
  logic [1:0] m_ptr;
  int         m_pkt [4];
  int         m_cur;
  int         m_pick;
  logic       p_v;
  logic [1:0] p_ch;
  int         p_idx;
  int         p_pkt;
  logic       e_valid;
  logic       e_sync;
  logic       e_err;
  logic [7:0] e_data;

  function automatic int pick(input logic [3:0] rdy, input logic [1:0] last);
    int r;
    r = -1;
`ifdef TS_ARB_CH0_PRIO_EN
    if (rdy[0]) return 0;
    rdy[0] = 1'b0;
`endif
    for (int k = 1; k <= 4; k++)
      if (r < 0 && rdy[(int'(last) + k) % 4]) r = (int'(last) + k) % 4;
    return r;
  endfunction

  assign m_pick = pick(ifc.pkt_rdy, m_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_off <= 0; m_gid <= 2'd0; m_ptr <= 2'd3; m_cur <= 0;
      for (int i = 0; i < 4; i++) m_pkt[i] <= 0;
      p_v <= 1'b0; p_ch <= 2'd0; p_idx <= 0; p_pkt <= 0;
      e_valid <= 1'b0; e_sync <= 1'b0; e_err <= 1'b0; e_data <= 8'h00;
    end else begin
      e_valid <= p_v;
      e_sync  <= p_v && (p_idx == 0);
      e_err   <= p_v && (p_idx == 0) && (pat(int'(p_ch), p_pkt, 0) != 8'h47);
      if (p_v) e_data <= pat(int'(p_ch), p_pkt, p_idx);
      p_v   <= (m_off >= 1) && (m_off <= PKT);
      p_ch  <= m_gid;
      p_idx <= m_off - 1;
      p_pkt <= m_cur;
      if (m_off == 0) begin
        if (ifc.arb_en && m_pick >= 0) begin
          m_gid          <= 2'(m_pick);
          m_cur          <= m_pkt[m_pick];
          m_pkt[m_pick]  <= m_pkt[m_pick] + 1;
          m_off          <= 1;
        end
      end else begin
        if (m_off == PKT) begin
`ifdef TS_ARB_CH0_PRIO_EN
          if (m_gid != 2'd0) m_ptr <= m_gid;
`else
          m_ptr <= m_gid;
`endif
        end
        m_off <= (m_off == PKT + GAP) ? 0 : m_off + 1;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("rd_en",    32'(ifc.rd_en), ((m_off >= 1) && (m_off <= PKT)) ? (32'd1 << m_gid) : 32'd0);
      chk("busy",     32'(ifc.busy), 32'(m_off != 0));
      chk("grant_id", 32'(ifc.grant_id), 32'(m_gid));
      chk("ts_valid", 32'(ifc.ts_valid), 32'(e_valid));
      chk("ts_sync",  32'(ifc.ts_sync), 32'(e_sync));
      chk("ts_data",  32'(ifc.ts_data), 32'(e_data));
      chk("sync_err", 32'(ifc.sync_err), 32'(e_err));
    end
  end

  // Event log used by the directed scenarios.
  int   cyc = 0;
  int   grants [$];
  int   grant_cyc [$];
  int   rd_runs [$];
  int   tv_runs [$];
  int   sync_data [$];
  int   serr_cnt;
  int   rd_run, tv_run;
  int   rd_first, tv_first;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (ifc.rd_en != 4'd0) begin
          if (rd_run == 0) begin
            grants.push_back(int'(ifc.grant_id));
            grant_cyc.push_back(cyc);
            if (rd_first < 0) rd_first = cyc;
          end
          rd_run++;
        end else if (rd_run > 0) begin
          rd_runs.push_back(rd_run);
          rd_run = 0;
        end
        if (ifc.ts_valid) begin
          if (tv_first < 0) tv_first = cyc;
          tv_run++;
        end else if (tv_run > 0) begin
          tv_runs.push_back(tv_run);
          tv_run = 0;
        end
        if (ifc.ts_sync) sync_data.push_back(int'(ifc.ts_data));
        if (ifc.sync_err) serr_cnt++;
      end else begin
        rd_run = 0;
        tv_run = 0;
      end
    end
  end

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] rdy);
    rst_n = 1'b0;
    repeat (3) step();
    grants.delete(); grant_cyc.delete(); rd_runs.delete(); tv_runs.delete(); sync_data.delete();
    serr_cnt = 0; rd_first = -1; tv_first = -1;
    ifc.arb_en  = 1'b1;
    ifc.pkt_rdy = rdy;
    rst_n = 1'b1;
  endtask

  task automatic wait_grants(input int n, input int bound);
    int i;
    i = 0;
    while (grants.size() < n && i < bound) begin
      step();
      i++;
    end
    chk("wait_grants", 32'(grants.size() >= n), 32'd1);
  endtask

  initial begin
    int exp_seq [5];
    int i;
    for (int c = 0; c < 4; c++) bad_first[c] = 1'b0;
    ifc.arb_en  = 1'b0;
    ifc.pkt_rdy = 4'd0;
    rd_run = 0; tv_run = 0; serr_cnt = 0; rd_first = -1; tv_first = -1;
    #1 rst_n = 1'b0;
    step();
    chk("rst_rd_en", 32'(ifc.rd_en), 32'd0);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_ts_valid", 32'(ifc.ts_valid), 32'd0);
    chk("rst_ts_data", 32'(ifc.ts_data), 32'd0);
    chk("rst_grant", 32'(ifc.grant_id), 32'd0);

    // Single requester on channel 0.
    do_reset(4'b0001);
    wait_grants(2, 600);
    chk("t1_first_grant", 32'(qat(grants, 0)), 32'd0);
    chk("t1_burst_len", 32'(qat(rd_runs, 0)), 32'd188);
    chk("t1_valid_len", 32'(qat(tv_runs, 0)), 32'd188);
    chk("t1_latency", 32'(tv_first - rd_first), 32'd2);
    chk("t1_period", 32'(qat(grant_cyc, 1) - qat(grant_cyc, 0)), 32'd193);
    chk("t1_sync_byte", 32'(qat(sync_data, 0)), 32'h47);

`ifdef TS_ARB_CH0_PRIO_EN
    do_reset(4'b1111);
    wait_grants(3, 800);
    for (int k = 0; k < 3; k++) chk("prio_ch0", 32'(qat(grants, k)), 32'd0);
    ifc.pkt_rdy = 4'b1110;
    wait_grants(7, 1200);
    exp_seq = '{1, 2, 3, 1, 0};
    for (int k = 0; k < 4; k++) chk("prio_rot", 32'(qat(grants, 3 + k)), 32'(exp_seq[k]));
`else
    // All four requesting: strict rotation.
    do_reset(4'b1111);
    wait_grants(5, 1200);
    exp_seq = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) chk("t2_rotation", 32'(qat(grants, k)), 32'(exp_seq[k]));
    for (int k = 0; k < 4; k++) chk("t2_valid_len", 32'(qat(tv_runs, k)), 32'd188);
`endif

    // Bad sync byte on channel 2.
    bad_first[2] = 1'b1;
    do_reset(4'b0100);
    wait_grants(1, 20);
    ifc.pkt_rdy = 4'b0000;
    i = 0;
    while (tv_runs.size() < 1 && i < 400) begin
      step();
      i++;
    end
    chk("t3_done", 32'(tv_runs.size()), 32'd1);
    chk("t3_serr_cnt", 32'(serr_cnt), 32'd1);
    chk("t3_len", 32'(qat(tv_runs, 0)), 32'd188);
    chk("t3_first_byte", 32'(qat(sync_data, 0)), 32'h00);
    chk("t3_grant", 32'(qat(grants, 0)), 32'd2);
    bad_first[2] = 1'b0;

`ifndef TS_ARB_CH0_PRIO_EN
    // arb_en dropped at byte 100 of the channel-1 packet.
    do_reset(4'b1111);
    wait_grants(2, 400);
    repeat (100) step();
    ifc.arb_en = 1'b0;
    repeat (400) step();
    chk("t4_no_new_grant", 32'(grants.size()), 32'd2);
    chk("t4_ch1_len", 32'(qat(tv_runs, 1)), 32'd188);
    chk("t4_hold_busy", 32'(ifc.busy), 32'd0);
    ifc.arb_en = 1'b1;
    wait_grants(3, 20);
    chk("t4_next_grant", 32'(qat(grants, 2)), 32'd2);
`endif

    // Reset in the middle of a packet.
    do_reset(4'b1111);
    wait_grants(1, 20);
    repeat (50) step();
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rd_en", 32'(ifc.rd_en), 32'd0);
    chk("t5_busy", 32'(ifc.busy), 32'd0);
    chk("t5_ts_valid", 32'(ifc.ts_valid), 32'd0);
    chk("t5_ts_sync", 32'(ifc.ts_sync), 32'd0);
    chk("t5_ts_data", 32'(ifc.ts_data), 32'd0);
    chk("t5_grant_id", 32'(ifc.grant_id), 32'd0);
    chk("t5_sync_err", 32'(ifc.sync_err), 32'd0);
    do_reset(4'b1111);
    wait_grants(2, 400);
    chk("t5_first_grant", 32'(qat(grants, 0)), 32'd0);
`ifdef TS_ARB_CH0_PRIO_EN
    chk("t5_second_grant", 32'(qat(grants, 1)), 32'd0);
`else
    chk("t5_second_grant", 32'(qat(grants, 1)), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
